// File: rtl/quadrature_position_counter.sv
// quadrature_position_counter
//   Samples raw encoder A/B/I pins through two-flop synchronisers and a
//   per-channel glitch filter, decodes A/B steps in 1x/2x/4x mode and keeps
//   a signed position counter with preload, index zeroing, index-position
//   capture and a sticky illegal-transition flag.
//
// Ports
//   clk             system clock, rising edge
//   reset           synchronous, active-high
//   quadA_in/B/I    raw asynchronous encoder pins
//   mode            00 = 1x, 01 = 2x, 10/11 = 4x
//   index_clear_en  index rising edge zeroes position when set
//   preload         one-cycle strobe, position <= preload_value
//   preload_value   value loaded by preload
//   clear_error     clears the sticky error flag
//   position        current count (two's complement, wraps)
//   index_position  position captured at the last index rising edge
//   count_pulse     one-cycle strobe per counted step
//   direction       1 = forward (A leads B), last counted step
//   index_pulse     one-cycle strobe per synchronised index rising edge
//   error           sticky illegal-transition flag
module quadrature_position_counter #(
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned FILTER_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   quadA_in,
  input  logic                   quadB_in,
  input  logic                   quadI_in,
  input  logic [1:0]             mode,
  input  logic                   index_clear_en,
  input  logic                   preload,
  input  logic [COUNT_WIDTH-1:0] preload_value,
  input  logic                   clear_error,
  output logic [COUNT_WIDTH-1:0] position,
  output logic [COUNT_WIDTH-1:0] index_position,
  output logic                   count_pulse,
  output logic                   direction,
  output logic                   index_pulse,
  output logic                   error
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [3:0]             FCNT_LAST = 4'(FILTER_DEPTH - 1);
  localparam logic [COUNT_WIDTH-1:0] ONE       = COUNT_WIDTH'(1);

  state_t                 r_state;
  logic [1:0]             r_init_cnt;
  logic [2:0]             r_meta;      // {A, B, I}
  logic [2:0]             r_sync;      // {A, B, I}
  logic                   r_filt_a, r_filt_b;
  logic                   r_prev_a, r_prev_b;
  logic [3:0]             r_fcnt_a, r_fcnt_b;
  logic                   r_i_prev;
  logic [COUNT_WIDTH-1:0] r_position;
  logic [COUNT_WIDTH-1:0] r_index_position;
  logic                   r_count_pulse;
  logic                   r_direction;
  logic                   r_index_pulse;
  logic                   r_error;

  logic w_run;
  logic w_step_a;
  logic w_step_b;
  logic w_illegal;
  logic w_dir;
  logic w_mode_ok;
  logic w_count;
  logic w_index_rise;

  // Returns {next_filt, next_fcnt}; the level only follows the synchronised
  // input after it has differed for FILTER_DEPTH consecutive cycles.
  function automatic logic [4:0] filt_step(input logic s, input logic f,
                                           input logic [3:0] c);
    if (s == f)
      return {f, 4'd0};
    else if (c == FCNT_LAST)
      return {s, 4'd0};
    else
      return {f, c + 4'd1};
  endfunction

  assign w_run        = (r_state == ST_RUN);
  assign w_step_a     = r_filt_a ^ r_prev_a;
  assign w_step_b     = r_filt_b ^ r_prev_b;
  assign w_illegal    = w_run & w_step_a & w_step_b;
  assign w_dir        = r_filt_a ^ r_prev_b;
  assign w_count      = w_run & (w_step_a ^ w_step_b) & w_mode_ok;
  assign w_index_rise = w_run & r_sync[0] & ~r_i_prev;

  always_comb begin
    w_mode_ok = 1'b1;
    if (!mode[1]) begin
      if (mode[0]) w_mode_ok = w_step_a;
      else         w_mode_ok = w_step_a & r_filt_a;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state          <= ST_INIT;
      r_init_cnt       <= '0;
      r_meta           <= '0;
      r_sync           <= '0;
      r_filt_a         <= 1'b0;
      r_filt_b         <= 1'b0;
      r_prev_a         <= 1'b0;
      r_prev_b         <= 1'b0;
      r_fcnt_a         <= '0;
      r_fcnt_b         <= '0;
      r_i_prev         <= 1'b0;
      r_position       <= '0;
      r_index_position <= '0;
      r_count_pulse    <= 1'b0;
      r_direction      <= 1'b0;
      r_index_pulse    <= 1'b0;
      r_error          <= 1'b0;
    end else begin
      r_meta <= {quadA_in, quadB_in, quadI_in};
      r_sync <= r_meta;

      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + 2'd1;
          // Seed filter and edge history from the settled pins so that the
          // first RUN cycle never sees a spurious step or index edge.
          if (r_init_cnt == 2'd2) begin
            r_filt_a <= r_sync[2];
            r_filt_b <= r_sync[1];
            r_prev_a <= r_sync[2];
            r_prev_b <= r_sync[1];
            r_i_prev <= r_sync[0];
            r_state  <= ST_RUN;
          end
        end
        ST_RUN: begin
          r_prev_a <= r_filt_a;
          r_prev_b <= r_filt_b;
          r_i_prev <= r_sync[0];
          {r_filt_a, r_fcnt_a} <= filt_step(r_sync[2], r_filt_a, r_fcnt_a);
          {r_filt_b, r_fcnt_b} <= filt_step(r_sync[1], r_filt_b, r_fcnt_b);
        end
        default: r_state <= ST_INIT;
      endcase

      r_count_pulse <= w_count;
      if (w_count) r_direction <= w_dir;

      r_index_pulse <= w_index_rise;
      if (w_index_rise) r_index_position <= r_position;

      if (preload)
        r_position <= preload_value;
      else if (w_index_rise && index_clear_en)
        r_position <= '0;
      else if (w_count)
        r_position <= w_dir ? r_position + ONE : r_position - ONE;

      // A new illegal step outranks a same-cycle clear.
      if (w_illegal)
        r_error <= 1'b1;
      else if (clear_error)
        r_error <= 1'b0;
    end
  end

  assign position       = r_position;
  assign index_position = r_index_position;
  assign count_pulse    = r_count_pulse;
  assign direction      = r_direction;
  assign index_pulse    = r_index_pulse;
  assign error          = r_error;

endmodule

// File: tb/tb_quadrature_position_counter.sv
module tb_quadrature_position_counter;

  localparam int CW = 32;
  localparam int FD = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pa = 1'b0, pb = 1'b0, pi = 1'b0;
  logic [1:0]    mode = 2'b10;
  logic          ice = 1'b0;
  logic          pl = 1'b0;
  logic [CW-1:0] plv = '0;
  logic          ce = 1'b0;

  logic [CW-1:0] position, index_position;
  logic          count_pulse, direction, index_pulse, error;

  int vectors = 0;
  int miscompares = 0;
  int cp_cnt = 0;
  int ip_cnt = 0;

  always #5 clk = ~clk;

  quadrature_position_counter #(.COUNT_WIDTH(CW), .FILTER_DEPTH(FD)) dut (
    .clk           (clk),
    .reset         (reset),
    .quadA_in      (pa),
    .quadB_in      (pb),
    .quadI_in      (pi),
    .mode          (mode),
    .index_clear_en(ice),
    .preload       (pl),
    .preload_value (plv),
    .clear_error   (ce),
    .position      (position),
    .index_position(index_position),
    .count_pulse   (count_pulse),
    .direction     (direction),
    .index_pulse   (index_pulse),
    .error         (error)
  );

  // ---------------- behavioural reference model ----------------
  // Steps are classified by their position on the quadrature cycle
  // 00 -> 10 -> 11 -> 01 (phase 0..3): +1 forward, +3 reverse, +2 illegal.
  function automatic int ab_phase(input bit a, input bit b);
    case ({a, b})
      2'b00:   return 0;
      2'b10:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  bit            m_valid = 0;
  int            m_cyc;
  bit            m_run;
  bit            pipeA[$], pipeB[$], pipeI[$];
  bit            histA[$], histB[$];
  bit            m_fa, m_fb, m_pa, m_pb, m_iprev;
  logic [CW-1:0] e_pos, e_ipos;
  bit            e_cp, e_dir, e_ip, e_err;

  always @(posedge clk) begin
    bit sa, sb, si, counted, fwd, illegal, rise, a_chg;
    int delta, nd;
    if (reset) begin
      m_valid = 1; m_cyc = 0; m_run = 0;
      pipeA = '{0, 0}; pipeB = '{0, 0}; pipeI = '{0, 0};
      histA.delete(); histB.delete();
      m_fa = 0; m_fb = 0; m_pa = 0; m_pb = 0; m_iprev = 0;
      e_pos = '0; e_ipos = '0; e_cp = 0; e_dir = 0; e_ip = 0; e_err = 0;
    end else begin
      sa = pipeA[0]; sb = pipeB[0]; si = pipeI[0];
      void'(pipeA.pop_front()); pipeA.push_back(pa);
      void'(pipeB.pop_front()); pipeB.push_back(pb);
      void'(pipeI.pop_front()); pipeI.push_back(pi);
      counted = 0; fwd = 0; illegal = 0; rise = 0;
      if (!m_run) begin
        e_cp = 0; e_ip = 0;
        if (m_cyc == 2) begin
          m_fa = sa; m_fb = sb; m_pa = sa; m_pb = sb; m_iprev = si; m_run = 1;
        end
        m_cyc++;
      end else begin
        delta   = (ab_phase(m_fa, m_fb) - ab_phase(m_pa, m_pb) + 4) % 4;
        a_chg   = (m_fa != m_pa);
        illegal = (delta == 2);
        fwd     = (delta == 1);
        if (delta == 1 || delta == 3)
          counted = mode[1] ? 1'b1 : (mode[0] ? a_chg : (a_chg && m_fa));
        m_pa = m_fa; m_pb = m_fb;
        // filtered level flips once the last FD sync samples all disagree
        histA.push_back(sa); if (histA.size() > FD) void'(histA.pop_front());
        histB.push_back(sb); if (histB.size() > FD) void'(histB.pop_front());
        nd = 0; foreach (histA[k]) if (histA[k] != m_fa) nd++;
        if (nd == FD) begin m_fa = sa; histA.delete(); end
        nd = 0; foreach (histB[k]) if (histB[k] != m_fb) nd++;
        if (nd == FD) begin m_fb = sb; histB.delete(); end
        rise = si && !m_iprev;
        m_iprev = si;
        e_cp = counted;
        if (counted) e_dir = fwd;
        e_ip = rise;
        if (rise) e_ipos = e_pos;
      end
      if (pl) e_pos = plv;
      else if (rise && ice) e_pos = '0;
      else if (counted) e_pos = fwd ? e_pos + 1 : e_pos - 1;
      if (illegal) e_err = 1;
      else if (ce) e_err = 0;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (m_valid) begin
      vectors++;
      if (position !== e_pos || index_position !== e_ipos || count_pulse !== e_cp ||
          direction !== e_dir || index_pulse !== e_ip || error !== e_err) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t: got pos=%h ipos=%h cp=%b dir=%b ip=%b err=%b, expected pos=%h ipos=%h cp=%b dir=%b ip=%b err=%b",
                 $time, position, index_position, count_pulse, direction, index_pulse, error,
                 e_pos, e_ipos, e_cp, e_dir, e_ip, e_err);
      end
    end
    if (count_pulse === 1'b1) cp_cnt++;
    if (index_pulse === 1'b1) ip_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic check_lit(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1; cyc(2); reset = 1'b0;
  endtask

  task automatic set_ab(input bit a, input bit b, input int hold);
    pa = a; pb = b; cyc(hold);
  endtask

  task automatic do_preload(input logic [CW-1:0] v);
    pl = 1'b1; plv = v; cyc(1); pl = 1'b0;
  endtask

  task automatic fwd_cycles(input int n);
    repeat (n) begin
      set_ab(1, 0, 8); set_ab(1, 1, 8); set_ab(0, 1, 8); set_ab(0, 0, 8);
    end
  endtask

  task automatic rev_cycles(input int n);
    repeat (n) begin
      set_ab(0, 1, 8); set_ab(1, 1, 8); set_ab(1, 0, 8); set_ab(0, 0, 8);
    end
  endtask

  initial begin
    int ph, r;
    @(negedge clk);

    // Pins held at 11 through reset: nothing may count or flag.
    pa = 1; pb = 1;
    do_reset();
    cp_cnt = 0;
    cyc(25);
    check_lit("idle11_position", position, 0);
    check_lit("idle11_error", {31'd0, error}, 0);
    check_lit("idle11_pulses", cp_cnt, 0);

    // Reset state with pins at 00.
    pa = 0; pb = 0;
    reset = 1'b1; cyc(2);
    check_lit("reset_position", position, 0);
    check_lit("reset_index_position", index_position, 0);
    check_lit("reset_flags", {28'd0, count_pulse, direction, index_pulse, error}, 0);
    reset = 1'b0;
    cyc(10);

    // 4x forward / reverse.
    mode = 2'b10; cp_cnt = 0;
    fwd_cycles(10); cyc(10);
    check_lit("4x_fwd_position", position, 40);
    check_lit("4x_fwd_pulses", cp_cnt, 40);
    check_lit("4x_fwd_direction", {31'd0, direction}, 1);
    rev_cycles(10); cyc(10);
    check_lit("4x_rev_position", position, 0);
    check_lit("4x_rev_direction", {31'd0, direction}, 0);

    // 2x then 1x.
    mode = 2'b01; fwd_cycles(10); cyc(10);
    check_lit("2x_fwd_position", position, 20);
    do_preload(0);
    mode = 2'b00; fwd_cycles(10); cyc(10);
    check_lit("1x_fwd_position", position, 10);

    // Short A glitch is filtered out.
    mode = 2'b10;
    set_ab(1, 0, 2); set_ab(0, 0, 12);
    check_lit("glitch_position", position, 10);

    // Wrap-around.
    do_preload(32'h7FFF_FFFF);
    set_ab(1, 0, 12);
    check_lit("wrap_max_plus1", position, 32'h8000_0000);
    do_preload(0);
    set_ab(0, 0, 12);
    check_lit("wrap_zero_minus1", position, 32'hFFFF_FFFF);

    // Index with clear enabled, same cycle as a forward step.
    do_preload(123);
    ice = 1; ip_cnt = 0;
    pa = 1; pb = 0; cyc(4);
    pi = 1; cyc(6);
    check_lit("idxclr_index_position", index_position, 123);
    check_lit("idxclr_position", position, 0);
    check_lit("idxclr_pulse_count", ip_cnt, 1);
    pi = 0; cyc(6);

    // Same again with clear disabled.
    do_preload(123);
    ice = 0;
    pa = 1; pb = 1; cyc(4);
    pi = 1; cyc(6);
    check_lit("idxnoclr_position", position, 124);
    check_lit("idxnoclr_index_position", index_position, 123);
    pi = 0; cyc(6);

    // Illegal transitions and error clearing.
    set_ab(0, 1, 12); set_ab(0, 0, 12);
    check_lit("pre_err_position", position, 126);
    set_ab(1, 1, 12);
    check_lit("illegal_error", {31'd0, error}, 1);
    check_lit("illegal_position", position, 126);
    pa = 0; pb = 0; cyc(6);
    ce = 1; cyc(1); ce = 0; cyc(3);
    check_lit("clear_vs_illegal_error", {31'd0, error}, 1);
    ce = 1; cyc(1); ce = 0; cyc(1);
    check_lit("clear_alone_error", {31'd0, error}, 0);
    check_lit("post_err_position", position, 126);

    // Randomised traffic.
    for (int n = 0; n < 4000; n++) begin
      reset = ($urandom_range(0, 999) < 2);
      if ($urandom_range(0, 99) < 8) begin
        ph = ab_phase(pa, pb);
        r  = $urandom_range(0, 19);
        ph = (ph + ((r == 0) ? 2 : ((r & 1) ? 1 : 3))) % 4;
        case (ph)
          0: begin pa = 0; pb = 0; end
          1: begin pa = 1; pb = 0; end
          2: begin pa = 1; pb = 1; end
          default: begin pa = 0; pb = 1; end
        endcase
      end
      if ($urandom_range(0, 99) < 5) pi = ~pi;
      if ($urandom_range(0, 99) < 1) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) < 2) ice = ~ice;
      pl = ($urandom_range(0, 99) < 1);
      case ($urandom_range(0, 4))
        0: plv = 32'h7FFF_FFFF;
        1: plv = 32'hFFFF_FFFF;
        2: plv = 32'h8000_0000;
        3: plv = '0;
        default: plv = $urandom;
      endcase
      ce = ($urandom_range(0, 99) < 3);
      cyc(1);
    end
    reset = 0; pl = 0; ce = 0;
    cyc(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/quadrature_position_counter.md
# quadrature_position_counter

Parametrised successor to the 4x quadrature decoder. It samples raw encoder A/B/I pins, runs each through a synchroniser and a digital glitch filter, and decodes edges in a run-time selectable 1x/2x/4x mode. It keeps a signed position counter with preload, optional index-zeroing and index-position capture, and flags illegal A/B transitions. It sits between the encoder pins and the motion-control register bank, replacing the decoder-plus-external-counter pair.

## Interface
- COUNT_WIDTH, 32: width of position and index_position, two's complement.
- FILTER_DEPTH, 4: consecutive stable cycles needed before a filtered A/B level changes; legal range 1..15.
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- quadA_in, quadB_in, quadI_in  in  1 each  raw asynchronous encoder pins.
- mode  in  2  00 = 1x, 01 = 2x, 10 = 4x, 11 = treated as 4x.
- index_clear_en  in  1  when 1, an index rising edge zeroes position.
- preload  in  1  one-cycle strobe: position <= preload_value.
- preload_value  in  COUNT_WIDTH  value loaded by preload.
- clear_error  in  1  clears the sticky error flag.
- position  out  COUNT_WIDTH  current count.
- index_position  out  COUNT_WIDTH  position value captured at the last index edge.
- count_pulse  out  1  one-cycle strobe per counted edge.
- direction  out  1  1 = forward (A leads B); holds the last counted step's direction.
- index_pulse  out  1  one-cycle strobe on each synchronised index rising edge.
- error  out  1  sticky illegal-transition flag.

## Operation
- Sync: each pin passes through 2 flops (a_s, b_s, i_s).
- FSM states: INIT and RUN. Reset enters INIT with init_cnt = 0. INIT increments init_cnt each cycle. When init_cnt == 2, filt_A/B and prev_A/B load directly from a_s/b_s, i_prev loads i_s, and the FSM moves to RUN. INIT produces no counts, index pulses or errors.
- Filter, RUN, per channel: if sync == filt, fcnt <= 0. Otherwise fcnt++. When sync != filt and fcnt == FILTER_DEPTH-1, filt <= sync and fcnt <= 0.
- Edge evaluation, RUN: prev_A/B <= filt_A/B every cycle. A step exists when {filt_A,filt_B} != {prev_A,prev_B}.
- Step direction: dir = filt_A ^ prev_B. Forward sequence is 00->10->11->01->00.
- Counted steps by mode:
  - 4x: any single-bit step.
  - 2x: any A change.
  - 1x: A rising only.
  - An uncounted step updates nothing but prev.
- Illegal step (A and B both change): error <= 1, nothing counted, prev still updates.
- Position update priority, highest first: preload; then index edge with index_clear_en; then counted step (+1 if dir, else -1).
  - Preload or index-clear wins over a same-cycle step. count_pulse and direction still reflect that step.
- Arithmetic is modulo 2^COUNT_WIDTH: max+1 wraps to min, 0-1 gives all-ones.
- Index, RUN: rising edge = i_s & ~i_prev. It raises index_pulse and captures index_position <= position (the pre-update value), independent of index_clear_en.
- Error flag: clear_error drops error unless a new illegal step occurs in the same cycle, in which case error stays 1.
- mode changes take effect on the next evaluated step; prev tracking is unaffected.

## Timing
- Reset values: position = 0, index_position = 0, count_pulse = 0, direction = 0, index_pulse = 0, error = 0. FSM = INIT, all filter, prev and sync flops = 0.
- Reset mid-operation: on the next edge, everything returns to reset values and INIT restarts. In-flight steps are discarded.
- Pin-to-output latency:
  - A/B: 2 (sync) + FILTER_DEPTH (filter) + 1 (registered outputs) cycles. This is 7 at default.
  - Index: 3 cycles to index_pulse.
  - preload: position updates 1 cycle after the strobe.
- Glitches shorter than FILTER_DEPTH cycles at the sync output are rejected.
- Maximum countable edge rate: one step per FILTER_DEPTH cycles per channel.

## Test plan
- Reset, then pins held at A=1, B=1: after INIT, filt = 11; no count_pulse and no error ever fire; position = 0.
- 4x, forward, 10 full cycles (00,10,11,01 with each level held 8 cycles): position = 40, 40 count_pulses, direction = 1. Repeat in reverse: position returns to 0, direction = 0.
- Same 10-cycle forward stimulus in 2x then 1x: position = 20 and 10. A 2-cycle A glitch at FILTER_DEPTH = 4 leaves position unchanged.
- Preload 32'h7FFFFFFF, then one forward 4x step: position = 32'h80000000. Preload 0, then one reverse step: position = 32'hFFFFFFFF.
- index_clear_en = 1 at position 123, index rises in the same cycle as a forward step: index_position = 123, position = 0, index_pulse for exactly 1 cycle. With index_clear_en = 0: position = 124.
- A and B toggled together 00->11: error = 1 and position unchanged. Assert clear_error in the same cycle as a second illegal step: error stays 1. Assert clear_error alone: error = 0.
